// File: rtl/systolic_array_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer.
// Holds the default array geometry, lane width, result FIFO sizing and the
// controller state encoding.
package systolic_array_ctrl_pkg;

    localparam int unsigned SA_PE_ROW     = 4;
    localparam int unsigned SA_PE_COL     = 4;
    localparam int unsigned SA_DATA_W     = 32;
    localparam int unsigned SA_FIFO_DEPTH = 8;
    localparam int unsigned SA_CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_WLOAD   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

endpackage

// File: rtl/systolic_array_ctrl_sa_result_fifo.sv
// Synchronous result FIFO between the systolic array and the output port.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   push, push_data    write side (written at the clock edge)
//   pop                read side; ignored while empty
//   valid, pop_data    FIFO non-empty and head entry
//   count              number of stored entries
// Push and pop in the same cycle are both honoured, including on a full FIFO.
module systolic_array_ctrl_sa_result_fifo
    import systolic_array_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = SA_PE_ROW * SA_DATA_W,
    parameter int unsigned DEPTH = SA_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       valid,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && (count != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign valid    = (count != '0);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Credit flow control upstream must make this impossible.
    push_when_full_a: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop));

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer in front of the systolic array: clears the array, loads PE_ROW
// weight beats, then streams num_vec input vectors and collects each result
// ARRAY_LAT cycles later into a result FIFO with ready/valid output.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   start, num_vec               job start pulse (IDLE only) and vector count
//   busy, done                   job in progress / one-cycle end-of-job pulse
//   wt_valid/wt_ready/wt_data    weight beat handshake
//   in_valid/in_ready/in_data    input vector handshake
//   out_valid/out_ready/out_data result handshake (FIFO head)
//   sa_reset, sa_mode            array clear, weight(1)/compute(0) mode
//   sa_data, sa_weight           registered array inputs
//   sa_result                    array result
// Feed is gated by credits so every in-flight result has a FIFO slot.
module systolic_array_ctrl
    import systolic_array_ctrl_pkg::*;
#(
    parameter int unsigned PE_ROW     = SA_PE_ROW,
    parameter int unsigned PE_COL     = SA_PE_COL,
    parameter int unsigned ARRAY_LAT  = PE_ROW + PE_COL - 1,
    parameter int unsigned FIFO_DEPTH = SA_FIFO_DEPTH,
    parameter int unsigned CNT_W      = SA_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_vec,
    output logic                        busy,
    output logic                        done,
    input  logic                        wt_valid,
    output logic                        wt_ready,
    input  logic [PE_COL*SA_DATA_W-1:0] wt_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PE_ROW*SA_DATA_W-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PE_ROW*SA_DATA_W-1:0] out_data,
    output logic                        sa_reset,
    output logic                        sa_mode,
    output logic [PE_ROW*SA_DATA_W-1:0] sa_data,
    output logic [PE_COL*SA_DATA_W-1:0] sa_weight,
    input  logic [PE_ROW*SA_DATA_W-1:0] sa_result
);

    localparam int unsigned DW     = PE_ROW * SA_DATA_W;
    localparam int unsigned WW     = PE_COL * SA_DATA_W;
    localparam int unsigned CRD_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WCNT_W = $clog2(PE_ROW + 1);

    state_e               state;
    state_e               state_nxt;
    logic [CNT_W-1:0]     remaining;
    logic [CNT_W-1:0]     remaining_nxt;
    logic [CRD_W-1:0]     credits;
    logic [CRD_W-1:0]     credits_nxt;
    logic [WCNT_W-1:0]    wt_cnt;
    logic [WCNT_W-1:0]    wt_cnt_nxt;
    logic                 sa_vld;
    logic                 sa_vld_nxt;
    logic [ARRAY_LAT-1:0] inflight;
    logic                 sa_mode_nxt;
    logic [WW-1:0]        sa_weight_nxt;
    logic [DW-1:0]        sa_data_nxt;
    logic                 wt_ready_nxt;
    logic                 in_ready_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;

    logic                 wt_acc;
    logic                 feed;
    logic                 pop;
    logic                 push;
    logic [CRD_W-1:0]     fifo_count;
    logic                 fifo_empty_after;
    logic                 drain_ok;

    assign wt_acc   = wt_valid && wt_ready;
    assign feed     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign push     = inflight[ARRAY_LAT-1];
    assign sa_reset = reset || (state == ST_CLR);

    // Job is finished once nothing is in the array and the last result leaves
    // this cycle (or already left), so done lands the cycle after the last pop.
    assign fifo_empty_after = (fifo_count == '0) || ((fifo_count == CRD_W'(1)) && pop);
    assign drain_ok         = !sa_vld && (inflight == '0) && fifo_empty_after;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLR;
            end
            ST_CLR: begin
                state_nxt = ST_WLOAD;
            end
            ST_WLOAD: begin
                if (wt_acc && (wt_cnt == WCNT_W'(PE_ROW - 1))) begin
                    state_nxt = (remaining == '0) ? ST_DRAIN : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (feed && (remaining == CNT_W'(1))) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_ok) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output and counter next values; all of these are registered below.
    always_comb begin
        remaining_nxt = remaining;
        credits_nxt   = credits;
        wt_cnt_nxt    = wt_cnt;
        sa_vld_nxt    = 1'b0;
        sa_mode_nxt   = 1'b0;
        sa_weight_nxt = '0;
        sa_data_nxt   = '0;
        done_nxt      = 1'b0;

        // A feed and a pop in the same cycle cancel out.
        case ({feed, pop})
            2'b10:   credits_nxt = credits - CRD_W'(1);
            2'b01:   credits_nxt = credits + CRD_W'(1);
            default: credits_nxt = credits;
        endcase

        case (state)
            ST_IDLE: begin
                if (start) begin
                    remaining_nxt = num_vec;
                    credits_nxt   = CRD_W'(FIFO_DEPTH);
                    wt_cnt_nxt    = '0;
                end
            end
            ST_WLOAD: begin
                if (wt_acc) begin
                    sa_mode_nxt   = 1'b1;
                    sa_weight_nxt = wt_data;
                    wt_cnt_nxt    = wt_cnt + WCNT_W'(1);
                end
            end
            ST_COMPUTE: begin
                if (feed) begin
                    sa_data_nxt   = in_data;
                    sa_vld_nxt    = 1'b1;
                    remaining_nxt = remaining - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                done_nxt = drain_ok;
            end
            default: ;
        endcase

        wt_ready_nxt = (state_nxt == ST_WLOAD);
        in_ready_nxt = (state_nxt == ST_COMPUTE) && (remaining_nxt != '0) && (credits_nxt != '0);
        busy_nxt     = (state_nxt != ST_IDLE);
    end

    // Datapath and registered outputs; the inflight pipe trails sa_vld so its
    // tail lines up with the matching sa_result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            credits   <= '0;
            wt_cnt    <= '0;
            sa_vld    <= 1'b0;
            inflight  <= '0;
            sa_mode   <= 1'b0;
            sa_weight <= '0;
            sa_data   <= '0;
            wt_ready  <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            remaining <= remaining_nxt;
            credits   <= credits_nxt;
            wt_cnt    <= wt_cnt_nxt;
            sa_vld    <= sa_vld_nxt;
            inflight  <= (inflight << 1) | ARRAY_LAT'(sa_vld);
            sa_mode   <= sa_mode_nxt;
            sa_weight <= sa_weight_nxt;
            sa_data   <= sa_data_nxt;
            wt_ready  <= wt_ready_nxt;
            in_ready  <= in_ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    systolic_array_ctrl_sa_result_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (sa_result),
        .pop       (pop),
        .valid     (out_valid),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl with a pass-through delay-line array stub.
module tb_systolic_array_ctrl;

    localparam int unsigned PE_ROW = 4;
    localparam int unsigned PE_COL = 4;
    localparam int unsigned LAT    = PE_ROW + PE_COL - 1;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DW     = PE_ROW * 32;
    localparam int unsigned WW     = PE_COL * 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             busy, done;
    logic             wt_valid, wt_ready;
    logic [WW-1:0]    wt_data;
    logic             in_valid, in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid, out_ready;
    logic [DW-1:0]    out_data;
    logic             sa_reset, sa_mode;
    logic [DW-1:0]    sa_data;
    logic [WW-1:0]    sa_weight;
    logic [DW-1:0]    sa_result;

    systolic_array_ctrl #(
        .PE_ROW(PE_ROW), .PE_COL(PE_COL), .ARRAY_LAT(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sa_reset(sa_reset), .sa_mode(sa_mode), .sa_data(sa_data), .sa_weight(sa_weight),
        .sa_result(sa_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array stub: result equals sa_data delayed by exactly LAT cycles.
    logic [DW-1:0] stub_q [LAT];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(LAT); i++) stub_q[i] <= '0;
        end else begin
            stub_q[0] <= sa_data;
            for (int i = 1; i < int'(LAT); i++) stub_q[i] <= stub_q[i-1];
        end
    end
    assign sa_result = stub_q[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-job observations gathered by run_job.
    int e_hs, e_arr, e_out, e_stat, e_ord;
    int n_pop, n_in, n_wt, n_mode, n_sarst, held_acc, done_pulses;
    bit timed_out;
    logic [DW-1:0] exp_q [$];
    int            rt_q  [$];

    // Drives one job and checks every cycle against the protocol model:
    // accepted vectors are queued with the cycle their result becomes visible
    // (accept cycle + LAT + 2) and must leave in acceptance order.
    task automatic run_job(input int n, input int wt_pct, input int in_pct, input int out_pct,
                           input int hold, input bit const_data, input bit restart,
                           input int abort_at);
        int done_cyc;
        bit prev_wt, prev_in, finished;
        logic [WW-1:0] prev_wdat;
        logic [DW-1:0] prev_idat;
        bit exp_wr, exp_ir, exp_ov, exp_busy, exp_done, wa, ia, pp;
        e_hs = 0; e_arr = 0; e_out = 0; e_stat = 0; e_ord = 0;
        n_pop = 0; n_in = 0; n_wt = 0; n_mode = 0; n_sarst = 0; held_acc = 0; done_pulses = 0;
        timed_out = 0;
        exp_q.delete(); rt_q.delete();
        done_cyc = -1; prev_wt = 0; prev_in = 0; prev_wdat = '0; prev_idat = '0; finished = 0;
        @(negedge clk);
        start = 1'b1; num_vec = CNT_W'(n);
        wt_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 1; k <= 4000 && !finished; k++) begin
            @(negedge clk);
            start    = 1'b0;
            exp_wr   = (k >= 2) && (n_wt < int'(PE_ROW));
            exp_ir   = (n_wt == int'(PE_ROW)) && (n_in < n) && ((n_in - n_pop) < int'(DEPTH));
            exp_ov   = (rt_q.size() > 0) && (rt_q[0] <= k);
            exp_done = (k == done_cyc);
            exp_busy = (done_cyc < 0) || (k < done_cyc);
            if (sa_reset !== (k == 1)) e_arr++;
            if (sa_mode !== prev_wt) e_arr++;
            if (sa_weight !== (prev_wt ? prev_wdat : WW'(0))) e_arr++;
            if (sa_data !== (prev_in ? prev_idat : DW'(0))) e_arr++;
            if (wt_ready !== exp_wr) e_hs++;
            if (in_ready !== exp_ir) e_hs++;
            if (out_valid !== exp_ov) e_out++;
            if (busy !== exp_busy) e_stat++;
            if (done !== exp_done) e_stat++;
            if (sa_reset === 1'b1) n_sarst++;
            if (sa_mode === 1'b1) n_mode++;
            if (done === 1'b1) done_pulses++;
            if (done_cyc >= 0 && k == done_cyc + 1) begin
                finished = 1;
            end else if (abort_at > 0 && n_in == abort_at) begin
                wt_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                return;
            end else begin
                wt_valid = (int'($urandom_range(99)) < wt_pct);
                in_valid = (int'($urandom_range(99)) < in_pct);
                if (const_data) begin
                    wt_data = {PE_COL{32'h40A00000}};
                    in_data = {PE_ROW{32'h41200000}};
                end else begin
                    for (int i = 0; i < int'(PE_COL); i++) wt_data[32*i +: 32] = $urandom;
                    for (int i = 0; i < int'(PE_ROW); i++) in_data[32*i +: 32] = $urandom;
                    in_data[DW-1 -: 32] = 32'(n_in);
                end
                out_ready = (k > hold) && (int'($urandom_range(99)) < out_pct);
                start     = restart && (done_cyc < 0) && (k % 3 == 0);
                num_vec   = CNT_W'($urandom);
                wa = wt_valid && (wt_ready === 1'b1);
                ia = in_valid && (in_ready === 1'b1);
                pp = out_ready && (out_valid === 1'b1);
                if (pp) begin
                    if (exp_q.size() == 0) e_ord++;
                    else begin
                        if (out_data !== exp_q[0]) e_ord++;
                        void'(exp_q.pop_front());
                        void'(rt_q.pop_front());
                    end
                    n_pop++;
                    if (n_pop == n) done_cyc = k + 1;
                end
                if (ia) begin
                    exp_q.push_back(in_data);
                    rt_q.push_back(k + int'(LAT) + 2);
                    n_in++;
                end
                if (wa) begin
                    n_wt++;
                    if (n_wt == int'(PE_ROW) && n == 0) done_cyc = k + 2;
                end
                if (k == hold) held_acc = n_in;
                prev_wt = wa; prev_wdat = wt_data;
                prev_in = ia; prev_idat = in_data;
            end
        end
        wt_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        if (!finished) timed_out = 1;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({busy, done, out_valid, wt_ready, in_ready, sa_mode, sa_reset} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, want 0000001", {busy, done, out_valid, wt_ready, in_ready, sa_mode, sa_reset});
        end
        n_checks++;
        if ({sa_data, sa_weight, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h, want all zero", sa_data, sa_weight, out_data);
        end
    endtask

    task automatic test_basic;
        run_job(3, 100, 100, 100, 0, 1'b1, 1'b0, 0);
        n_checks++;
        if ((e_hs + e_arr + int'(timed_out)) !== 0) begin
            n_fail++; $display("FAIL basic_drive: got %0d errors, want 0", e_hs + e_arr + int'(timed_out));
        end
        n_checks++;
        if ((e_out + e_ord + e_stat) !== 0) begin
            n_fail++; $display("FAIL basic_output: got %0d errors, want 0", e_out + e_ord + e_stat);
        end
        n_checks++;
        if (n_pop !== 3) begin n_fail++; $display("FAIL basic_results: got %0d, want 3", n_pop); end
        n_checks++;
        if (n_mode !== int'(PE_ROW)) begin
            n_fail++; $display("FAIL basic_mode_beats: got %0d, want %0d", n_mode, PE_ROW);
        end
        n_checks++;
        if (n_sarst !== 1) begin n_fail++; $display("FAIL basic_sa_reset: got %0d cycles, want 1", n_sarst); end
    endtask

    task automatic test_zero_vec;
        run_job(0, 100, 100, 100, 0, 1'b0, 1'b0, 0);
        n_checks++;
        if ((e_hs + e_arr + e_stat + int'(timed_out)) !== 0) begin
            n_fail++; $display("FAIL zero_protocol: got %0d errors, want 0", e_hs + e_arr + e_stat + int'(timed_out));
        end
        n_checks++;
        if ((e_out + n_pop + n_in) !== 0) begin
            n_fail++; $display("FAIL zero_no_output: got %0d, want 0", e_out + n_pop + n_in);
        end
        n_checks++;
        if (done_pulses !== 1) begin n_fail++; $display("FAIL zero_done: got %0d pulses, want 1", done_pulses); end
    endtask

    task automatic test_backpressure;
        run_job(20, 100, 100, 100, 60, 1'b0, 1'b0, 0);
        n_checks++;
        if (held_acc !== int'(DEPTH)) begin
            n_fail++; $display("FAIL bp_credit_limit: got %0d accepted, want %0d", held_acc, DEPTH);
        end
        n_checks++;
        if ((e_hs + e_arr + e_out + e_stat + int'(timed_out)) !== 0) begin
            n_fail++; $display("FAIL bp_protocol: got %0d errors, want 0", e_hs + e_arr + e_out + e_stat + int'(timed_out));
        end
        n_checks++;
        if (e_ord !== 0 || n_pop !== 20) begin
            n_fail++; $display("FAIL bp_order: got %0d order errors / %0d results, want 0 / 20", e_ord, n_pop);
        end
    endtask

    task automatic test_gaps;
        int errs = 0;
        int miss = 0;
        for (int j = 0; j < 3; j++) begin
            int n = 5 + int'($urandom_range(14));
            run_job(n, 50, 50, 70, 0, 1'b0, 1'b0, 0);
            errs += e_hs + e_arr + e_out + e_stat + e_ord + int'(timed_out);
            if (n_pop != n) miss++;
        end
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL gaps_protocol: got %0d errors, want 0", errs); end
        n_checks++;
        if (miss !== 0) begin n_fail++; $display("FAIL gaps_count: got %0d short jobs, want 0", miss); end
    endtask

    task automatic test_restart_ignored;
        run_job(6, 80, 80, 80, 0, 1'b0, 1'b1, 0);
        n_checks++;
        if ((e_hs + e_arr + e_out + e_stat + e_ord + int'(timed_out)) !== 0) begin
            n_fail++; $display("FAIL restart_protocol: got %0d errors, want 0", e_hs + e_arr + e_out + e_stat + e_ord + int'(timed_out));
        end
        n_checks++;
        if (n_in !== 6 || n_pop !== 6 || done_pulses !== 1) begin
            n_fail++; $display("FAIL restart_count: got in=%0d out=%0d done=%0d, want 6 6 1", n_in, n_pop, done_pulses);
        end
    endtask

    task automatic test_reset_midjob;
        int bad = 0;
        run_job(5, 100, 100, 100, 0, 1'b0, 1'b0, 2);
        reset = 1'b1;
        #1;
        n_checks++;
        if (n_in !== 2) begin n_fail++; $display("FAIL midreset_setup: got %0d fed, want 2", n_in); end
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d bad cycles, want 0", bad); end
        run_job(3, 100, 100, 100, 0, 1'b0, 1'b0, 0);
        n_checks++;
        if ((e_hs + e_arr + e_out + e_stat + e_ord + int'(timed_out)) !== 0 || n_pop !== 3) begin
            n_fail++; $display("FAIL midreset_rerun: got %0d errors / %0d results, want 0 / 3", e_hs + e_arr + e_out + e_stat + e_ord + int'(timed_out), n_pop);
        end
    endtask

    task automatic test_back_to_back;
        int errs = 0;
        for (int j = 0; j < 4; j++) begin
            int n = 1 + int'($urandom_range(15));
            run_job(n, 60 + int'($urandom_range(40)), 60 + int'($urandom_range(40)),
                    30 + int'($urandom_range(70)), 0, 1'b0, 1'b0, 0);
            errs += e_hs + e_arr + e_out + e_stat + e_ord + int'(timed_out);
            if (n_pop != n) errs++;
        end
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL b2b_jobs: got %0d errors, want 0", errs); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_vec = '0;
        wt_valid = 1'b0; wt_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_basic();
        test_zero_vec();
        test_backpressure();
        test_gaps();
        test_restart_ignored();
        test_reset_midjob();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
